// File: rtl/phys_reg_free_list.sv
// Physical register free list for the rename stage.
// Two independent circular pools (D and S) are refilled by ROB commit and
// drained by rename allocation. Grants are combinational from the pool head,
// so rename sees the register number in the same cycle it requests it.

// One circular FIFO of free physical register numbers.
// After reset, entry i holds BASE+i and the pool starts full.
module phys_reg_free_pool #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6,
  parameter int CAP    = 16,
  parameter int BASE   = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push_req,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop_req,
  output logic [ADDR_W-1:0] head_addr,
  output logic              avail,
  output logic [CNT_W-1:0]  count,
  output logic              push_drop
);

  localparam int PTR_W = (CAP > 1) ? $clog2(CAP) : 1;

  logic [ADDR_W-1:0] fifo [CAP];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Pointers wrap at the pool capacity, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CAP - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign avail     = (cnt != '0);
  assign full      = (cnt == CNT_W'(CAP));
  // No bypass: a pop on an empty pool is refused even if a push lands now.
  assign do_pop    = pop_req & avail;
  // A push into a full pool is dropped; the caller flags it as an error.
  assign do_push   = push_req & ~full;
  assign push_drop = push_req & full;
  assign head_addr = fifo[head];
  assign count     = cnt;

  // Pool storage, pointers and occupancy; reset reloads the initial free set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < CAP; i++) begin
        fifo[i] <= ADDR_W'(BASE + i);
      end
      head <= '0;
      tail <= '0;
      cnt  <= CNT_W'(CAP);
    end else begin
      if (do_push) begin
        fifo[tail] <= push_addr;
        tail       <= ptr_inc(tail);
      end
      if (do_pop) begin
        head <= ptr_inc(head);
      end
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

module phys_reg_free_list #(
  parameter int D_REGS = 32,
  parameter int D_ARCH = 16,
  parameter int S_REGS = 16,
  parameter int S_ARCH = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      commit_valid,
  input  logic                      commit_use_rw,
  input  logic [$clog2(D_REGS)-1:0] commit_prev_rw_addr,
  input  logic                      commit_use_rs,
  input  logic [$clog2(S_REGS)-1:0] commit_prev_rs_addr,
  input  logic                      alloc_rw_req,
  output logic [$clog2(D_REGS)-1:0] alloc_rw_addr,
  output logic                      alloc_rw_avail,
  input  logic                      alloc_rs_req,
  output logic [$clog2(S_REGS)-1:0] alloc_rs_addr,
  output logic                      alloc_rs_avail,
  output logic                      stall,
  output logic [$clog2(D_REGS):0]   d_free_count,
  output logic [$clog2(S_REGS):0]   s_free_count,
  output logic                      overflow_err
);

  localparam int DA_W = $clog2(D_REGS);
  localparam int SA_W = $clog2(S_REGS);

  logic d_drop;
  logic s_drop;

  phys_reg_free_pool #(
    .ADDR_W (DA_W),
    .CNT_W  (DA_W + 1),
    .CAP    (D_REGS - D_ARCH),
    .BASE   (D_ARCH)
  ) u_d_pool (
    .clk       (clk),
    .n_rst     (n_rst),
    .push_req  (commit_valid & commit_use_rw),
    .push_addr (commit_prev_rw_addr),
    .pop_req   (alloc_rw_req),
    .head_addr (alloc_rw_addr),
    .avail     (alloc_rw_avail),
    .count     (d_free_count),
    .push_drop (d_drop)
  );

  phys_reg_free_pool #(
    .ADDR_W (SA_W),
    .CNT_W  (SA_W + 1),
    .CAP    (S_REGS - S_ARCH),
    .BASE   (S_ARCH)
  ) u_s_pool (
    .clk       (clk),
    .n_rst     (n_rst),
    .push_req  (commit_valid & commit_use_rs),
    .push_addr (commit_prev_rs_addr),
    .pop_req   (alloc_rs_req),
    .head_addr (alloc_rs_addr),
    .avail     (alloc_rs_avail),
    .count     (s_free_count),
    .push_drop (s_drop)
  );

  assign stall = (alloc_rw_req & ~alloc_rw_avail) | (alloc_rs_req & ~alloc_rs_avail);

  // Sticky flag: any free dropped because its pool was already full.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_err <= 1'b0;
    end else if (d_drop | s_drop) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list with hand-computed expectations.
module tb_phys_reg_free_list;

  logic       clk;
  logic       n_rst;
  logic       commit_valid;
  logic       commit_use_rw;
  logic [4:0] commit_prev_rw_addr;
  logic       commit_use_rs;
  logic [3:0] commit_prev_rs_addr;
  logic       alloc_rw_req;
  logic [4:0] alloc_rw_addr;
  logic       alloc_rw_avail;
  logic       alloc_rs_req;
  logic [3:0] alloc_rs_addr;
  logic       alloc_rs_avail;
  logic       stall;
  logic [5:0] d_free_count;
  logic [4:0] s_free_count;
  logic       overflow_err;

  int n_cmp;
  int n_bad;

  phys_reg_free_list #(
    .D_REGS (32),
    .D_ARCH (16),
    .S_REGS (16),
    .S_ARCH (4)
  ) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .commit_valid        (commit_valid),
    .commit_use_rw       (commit_use_rw),
    .commit_prev_rw_addr (commit_prev_rw_addr),
    .commit_use_rs       (commit_use_rs),
    .commit_prev_rs_addr (commit_prev_rs_addr),
    .alloc_rw_req        (alloc_rw_req),
    .alloc_rw_addr       (alloc_rw_addr),
    .alloc_rw_avail      (alloc_rw_avail),
    .alloc_rs_req        (alloc_rs_req),
    .alloc_rs_addr       (alloc_rs_addr),
    .alloc_rs_avail      (alloc_rs_avail),
    .stall               (stall),
    .d_free_count        (d_free_count),
    .s_free_count        (s_free_count),
    .overflow_err        (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    commit_valid        = 1'b0;
    commit_use_rw       = 1'b0;
    commit_prev_rw_addr = '0;
    commit_use_rs       = 1'b0;
    commit_prev_rs_addr = '0;
    alloc_rw_req        = 1'b0;
    alloc_rs_req        = 1'b0;
  endtask

  task automatic push_d(input int a);
    commit_valid        = 1'b1;
    commit_use_rw       = 1'b1;
    commit_prev_rw_addr = 5'(a);
    tick();
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;

    // Reset state
    chk("rst_rw_addr", alloc_rw_addr, 16);
    chk("rst_rs_addr", alloc_rs_addr, 4);
    chk("rst_d_count", d_free_count, 16);
    chk("rst_s_count", s_free_count, 12);
    chk("rst_stall", stall, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_rw_avail", alloc_rw_avail, 1);
    tick();

    // Drain the D pool: grants 16..31 in order
    for (int i = 0; i < 16; i++) begin
      alloc_rw_req = 1'b1;
      #1;
      chk($sformatf("drain_addr_%0d", i), alloc_rw_addr, 16 + i);
      chk($sformatf("drain_stall_%0d", i), stall, 0);
      tick();
    end
    chk("drain_d_count", d_free_count, 0);
    chk("drain_rw_avail", alloc_rw_avail, 0);
    #1;
    chk("empty_stall", stall, 1);
    tick();
    alloc_rw_req = 1'b0;
    chk("empty_d_count", d_free_count, 0);
    chk("empty_s_untouched", s_free_count, 12);

    // Empty pool: push and pop together, no bypass
    commit_valid        = 1'b1;
    commit_use_rw       = 1'b1;
    commit_prev_rw_addr = 5'd5;
    alloc_rw_req        = 1'b1;
    #1;
    chk("nobypass_stall", stall, 1);
    tick();
    idle_inputs();
    chk("nobypass_avail", alloc_rw_avail, 1);
    chk("nobypass_addr", alloc_rw_addr, 5);
    chk("nobypass_count", d_free_count, 1);

    // Fill to 8 entries: 5, 8..14
    for (int k = 0; k < 7; k++) push_d(8 + k);
    chk("fill_count", d_free_count, 8);

    // Push 7 and pop together: count holds at 8
    commit_valid        = 1'b1;
    commit_use_rw       = 1'b1;
    commit_prev_rw_addr = 5'd7;
    alloc_rw_req        = 1'b1;
    #1;
    chk("pp_addr", alloc_rw_addr, 5);
    chk("pp_stall", stall, 0);
    tick();
    idle_inputs();
    chk("pp_count", d_free_count, 8);
    for (int k = 0; k < 8; k++) begin
      alloc_rw_req = 1'b1;
      #1;
      chk($sformatf("order_%0d", k), alloc_rw_addr, (k < 7) ? (8 + k) : 7);
      tick();
    end
    alloc_rw_req = 1'b0;
    chk("order_count", d_free_count, 0);

    // Ten entries cross the wrap point of the circular buffer
    for (int k = 0; k < 10; k++) push_d(20 + k);
    chk("wrap_count", d_free_count, 10);
    for (int k = 0; k < 10; k++) begin
      alloc_rw_req = 1'b1;
      #1;
      chk($sformatf("wrap_addr_%0d", k), alloc_rw_addr, 20 + k);
      tick();
    end
    alloc_rw_req = 1'b0;
    chk("wrap_end_count", d_free_count, 0);

    // Push into the full S pool
    commit_valid        = 1'b1;
    commit_use_rs       = 1'b1;
    commit_prev_rs_addr = 4'd2;
    tick();
    idle_inputs();
    chk("ovf_s_count", s_free_count, 12);
    chk("ovf_set", overflow_err, 1);
    tick();
    chk("ovf_sticky", overflow_err, 1);

    // Full S pool, push with a pop in the same cycle
    commit_valid        = 1'b1;
    commit_use_rs       = 1'b1;
    commit_prev_rs_addr = 4'd2;
    alloc_rs_req        = 1'b1;
    #1;
    chk("ovfpop_addr", alloc_rs_addr, 4);
    tick();
    idle_inputs();
    chk("ovfpop_count", s_free_count, 11);
    chk("ovfpop_ovf", overflow_err, 1);
    chk("ovfpop_next", alloc_rs_addr, 5);

    // use_rs without commit_valid is ignored
    commit_use_rs       = 1'b1;
    commit_prev_rs_addr = 4'd3;
    tick();
    idle_inputs();
    chk("novalid_count", s_free_count, 11);

    // D empty stalls, but S still pops
    alloc_rw_req = 1'b1;
    alloc_rs_req = 1'b1;
    #1;
    chk("indep_stall", stall, 1);
    tick();
    idle_inputs();
    chk("indep_s_count", s_free_count, 10);
    chk("indep_rs_addr", alloc_rs_addr, 6);
    chk("indep_d_count", d_free_count, 0);

    // Asynchronous reset mid-cycle with D count 3 and requests active
    push_d(1);
    push_d(2);
    push_d(3);
    chk("pre_arst_count", d_free_count, 3);
    alloc_rw_req = 1'b1;
    alloc_rs_req = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_rw_addr", alloc_rw_addr, 16);
    chk("arst_rs_addr", alloc_rs_addr, 4);
    chk("arst_d_count", d_free_count, 16);
    chk("arst_s_count", s_free_count, 12);
    chk("arst_ovf", overflow_err, 0);
    chk("arst_stall", stall, 0);
    idle_inputs();
    tick();
    n_rst = 1'b1;
    tick();
    chk("post_rst_d_count", d_free_count, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Receiving end of the ROB commit interface: returns the previous physical mappings that commit releases to two free pools, one for D registers and one for S registers.
- Hands free physical registers to the rename stage, one D and one S per cycle.
- Sits between the reorder buffer commit port and the rename/allocation logic.
- Raises a stall when rename asks for a register and none is free.

Parameters:
- D_REGS, 32, number of physical D registers (power of 2).
- D_ARCH, 16, number of architectural D registers. Physical regs 0..D_ARCH-1 are mapped at reset; the rest are free.
- S_REGS, 16, number of physical S registers (power of 2).
- S_ARCH, 4, number of architectural S registers. Physical regs 0..S_ARCH-1 are mapped at reset.

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- commit_valid  input  1  ROB commit strobe
- commit_use_rw  input  1  committed instr released a D reg
- commit_prev_rw_addr  input  $clog2(D_REGS)  D reg to free
- commit_use_rs  input  1  committed instr released an S reg
- commit_prev_rs_addr  input  $clog2(S_REGS)  S reg to free
- alloc_rw_req  input  1  rename requests one D reg this cycle
- alloc_rw_addr  output  $clog2(D_REGS)  D reg granted (head of D pool)
- alloc_rw_avail  output  1  D pool non-empty
- alloc_rs_req  input  1  rename requests one S reg this cycle
- alloc_rs_addr  output  $clog2(S_REGS)  S reg granted (head of S pool)
- alloc_rs_avail  output  1  S pool non-empty
- stall  output  1  a request cannot be served this cycle
- d_free_count  output  $clog2(D_REGS)+1  D pool occupancy
- s_free_count  output  $clog2(S_REGS)+1  S pool occupancy
- overflow_err  output  1  sticky: a free was attempted into a full pool

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on n_rst, and is fixed as such.
- Pool structure: each pool is a circular FIFO with its own head, tail and count.
  - D pool capacity is D_REGS-D_ARCH; S pool capacity is S_REGS-S_ARCH.
  - Pointers wrap modulo capacity.
- Reset, taking effect immediately on n_rst low, including mid-operation:
  - D entry i holds D_ARCH+i; head=0, tail=0 (pool full).
  - d_free_count = D_REGS-D_ARCH (16).
  - S pool is initialised the same way, giving s_free_count = 12.
  - overflow_err = 0 and stall = 0.
  - alloc_rw_addr = 16 and alloc_rs_addr = 4.
  - Any in-flight request or commit in that cycle is discarded.
- Combinational outputs:
  - alloc_*_addr = fifo[head].
  - alloc_*_avail = (count != 0).
  - stall = (alloc_rw_req & ~alloc_rw_avail) | (alloc_rs_req & ~alloc_rs_avail).
- Pop: on a clock edge with req & avail, head advances and count decrements.
  - Rename latches alloc_*_addr in that same cycle, so the grant has zero latency.
  - A request while the pool is empty does nothing beyond stall.
  - D and S pools are independent: a stalled D request does not block a valid S pop, and vice versa.
- Push: on a clock edge with commit_valid & commit_use_rw, the prev address is written at tail; tail advances and count increments. The S pool works the same way with commit_use_rs.
  - use_* is ignored when commit_valid = 0.
- Simultaneous push and pop on a non-empty pool: both happen and count is unchanged.
- Simultaneous push and pop on an empty pool: there is no bypass. The pop is refused (stall = 1), the push lands, and avail rises the next cycle.
- Push into a full pool (count == capacity):
  - The write is dropped and pointers are unchanged.
  - overflow_err sets and stays set until reset.
  - A pop in the same cycle still happens, after which count = capacity-1.
- Address values are not range-checked; freeing an architectural-range index is legal.

Test Plan:
- Reset, no activity → alloc_rw_addr=16, alloc_rs_addr=4, d_free_count=16, s_free_count=12, stall=0, overflow_err=0.
- alloc_rw_req=1 for 16 consecutive cycles → grants 16,17,…,31 in order, d_free_count reaches 0. The 17th cycle gives stall=1 with d_free_count still 0, and the S pool is untouched (12).
- D pool empty; commit_valid=1, use_rw=1, prev_rw_addr=5, together with alloc_rw_req=1 in the same cycle → stall=1 that cycle. Next cycle alloc_rw_avail=1, alloc_rw_addr=5, d_free_count=1.
- Mid-fill D pool (count=8); push prev_rw_addr=7 and pop in the same cycle → d_free_count stays 8, and 7 comes out after the 8 older entries (FIFO order preserved across wrap).
- Full S pool; commit use_rs=1, prev_rs_addr=2 → s_free_count stays 12, overflow_err=1, and it stays 1 until n_rst. Repeat with a simultaneous alloc_rs_req → s_free_count=11, overflow_err=1.
- Assert n_rst low asynchronously between edges while D count=3 and requests are active → outputs return to reset values immediately, without waiting for a clk edge.
